// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial_link transceiver.
package serial_link_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  // Parity over a zero-extended payload; zero padding does not change the XOR.
  function automatic logic calcParity(input logic [15:0] data, input bit oddMode);
    return (^data) ^ oddMode;
  endfunction

endpackage

// File: rtl/serial_link_baud_tick_gen.sv
// Oversample prescaler: one-cycle tick every DIV clocks, restartable by clear.
module baud_tick_gen
  import serial_link_pkg::*;
#(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running 0..DIV-1 counter, restarted from zero on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A clear in the same cycle suppresses the tick so the new period starts clean.
  assign tick = (cnt == CNT_LAST) && !clear;

endmodule

// File: rtl/serial_link.sv
// Full-duplex asynchronous serial transceiver: valid/ready transmitter and
// oversampling mid-bit receiver sharing one clock.
//
// TX state  | meaning
// TX_IDLE   | line high, tx_ready high, waiting for tx_valid
// TX_START  | driving the start bit (0)
// TX_DATA   | driving data bits, LSB first
// TX_PARITY | driving the parity bit
// TX_STOP   | driving STOP_BITS stop bits (1)
//
// RX state  | meaning
// RX_IDLE   | waiting for a synchronised 0
// RX_START  | half-bit wait, then glitch check of the start bit
// RX_DATA   | sampling data bits at mid-bit
// RX_PARITY | sampling the parity bit
// RX_STOP   | sampling the first stop bit, then publishing the word
// RX_BREAK  | stop bit was low; waiting for the line to return high
module serial_link
  import serial_link_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CLK_DIV    = 27,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = PARITY_MODE_EVEN,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  input  logic              serial_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);
  localparam logic [4:0] STOP_LAST = 5'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_t         txState, txNext;
  logic [DATA_W-1:0] txShift, txShifted;
  logic              txParity;
  logic [4:0]        txBitCnt;
  logic [TICK_W-1:0] txTickCnt;
  logic              txTick, txBitDone;
  logic              txLoad, txShiftEn, txBitClr, txBitInc, txLineNext;

  baud_tick_gen #(.DIV(CLK_DIV)) txBaud (
    .clk  (clk),
    .reset(reset),
    .clear(txLoad),
    .tick (txTick)
  );

  assign txBitDone = txTick && (txTickCnt == TICK_LAST);
  assign txShifted = txShift >> 1;
  assign tx_ready  = (txState == TX_IDLE);

  // TX next state and next line level; the line is registered to stay glitch-free.
  always_comb begin
    txNext     = txState;
    txLineNext = serial_out;
    txLoad     = 1'b0;
    txShiftEn  = 1'b0;
    txBitClr   = 1'b0;
    txBitInc   = 1'b0;
    case (txState)
      TX_IDLE: begin
        txLineNext = 1'b1;
        if (tx_valid) begin
          txNext     = TX_START;
          txLineNext = 1'b0;
          txLoad     = 1'b1;
        end
      end
      TX_START: begin
        if (txBitDone) begin
          txNext     = TX_DATA;
          txLineNext = txShift[0];
          txBitClr   = 1'b1;
        end
      end
      TX_DATA: begin
        if (txBitDone) begin
          if (txBitCnt == DATA_LAST) begin
            txBitClr = 1'b1;
            if (PARITY_EN) begin
              txNext     = TX_PARITY;
              txLineNext = txParity;
            end else begin
              txNext     = TX_STOP;
              txLineNext = 1'b1;
            end
          end else begin
            txShiftEn  = 1'b1;
            txBitInc   = 1'b1;
            txLineNext = txShifted[0];
          end
        end
      end
      TX_PARITY: begin
        if (txBitDone) begin
          txNext     = TX_STOP;
          txLineNext = 1'b1;
          txBitClr   = 1'b1;
        end
      end
      TX_STOP: begin
        txLineNext = 1'b1;
        if (txBitDone) begin
          if (txBitCnt == STOP_LAST) begin
            txNext = TX_IDLE;
          end else begin
            txBitInc = 1'b1;
          end
        end
      end
      default: begin
        txNext     = TX_IDLE;
        txLineNext = 1'b1;
      end
    endcase
  end

  // TX state, line register, payload shifter and bit/tick counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState    <= TX_IDLE;
      serial_out <= 1'b1;
      txShift    <= '0;
      txParity   <= 1'b0;
      txBitCnt   <= '0;
      txTickCnt  <= '0;
    end else begin
      txState    <= txNext;
      serial_out <= txLineNext;
      if (txLoad) begin
        txShift  <= tx_data;
        txParity <= calcParity(16'(tx_data), PARITY_ODD);
      end else if (txShiftEn) begin
        txShift <= txShifted;
      end
      if (txLoad || txBitClr) begin
        txBitCnt <= '0;
      end else if (txBitInc) begin
        txBitCnt <= txBitCnt + 5'd1;
      end
      if (txLoad) begin
        txTickCnt <= '0;
      end else if (txTick) begin
        txTickCnt <= (txTickCnt == TICK_LAST) ? '0 : txTickCnt + TICK_W'(1);
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t         rxState, rxNext;
  logic              rxMeta, rxSync;
  logic [DATA_W-1:0] rxShift, rxShifted;
  logic              rxParBit;
  logic [4:0]        rxBitCnt;
  logic [TICK_W-1:0] rxTickCnt;
  logic              rxTick, rxBitDone, rxHalfDone;
  logic              rxClear, rxRestart, rxSample, rxCapParity, rxFinish;
  logic              rxBitClr, rxBitInc;

  baud_tick_gen #(.DIV(CLK_DIV)) rxBaud (
    .clk  (clk),
    .reset(reset),
    .clear(rxClear),
    .tick (rxTick)
  );

  assign rxBitDone  = rxTick && (rxTickCnt == TICK_LAST);
  assign rxHalfDone = rxTick && (rxTickCnt == TICK_HALF);

  // New sample enters at the MSB so the first (LSB) bit ends up in bit 0.
  always_comb begin
    rxShifted = rxShift >> 1;
    rxShifted[DATA_W-1] = rxSync;
  end

  // RX next state; the tick counter is re-phased at mid start bit.
  always_comb begin
    rxNext      = rxState;
    rxClear     = 1'b0;
    rxRestart   = 1'b0;
    rxSample    = 1'b0;
    rxCapParity = 1'b0;
    rxFinish    = 1'b0;
    rxBitClr    = 1'b0;
    rxBitInc    = 1'b0;
    case (rxState)
      RX_IDLE: begin
        if (!rxSync) begin
          rxNext  = RX_START;
          rxClear = 1'b1;
        end
      end
      RX_START: begin
        if (rxHalfDone) begin
          if (rxSync) begin
            rxNext = RX_IDLE;
          end else begin
            rxNext    = RX_DATA;
            rxRestart = 1'b1;
            rxBitClr  = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (rxBitDone) begin
          rxSample = 1'b1;
          if (rxBitCnt == DATA_LAST) begin
            rxNext = PARITY_EN ? RX_PARITY : RX_STOP;
          end else begin
            rxBitInc = 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rxBitDone) begin
          rxCapParity = 1'b1;
          rxNext      = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rxBitDone) begin
          rxFinish = 1'b1;
          rxNext   = rxSync ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rxSync) begin
          rxNext = RX_IDLE;
        end
      end
      default: rxNext = RX_IDLE;
    endcase
  end

  // Synchroniser, RX state, sample capture and published outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta        <= 1'b1;
      rxSync        <= 1'b1;
      rxState       <= RX_IDLE;
      rxShift       <= '0;
      rxParBit      <= 1'b0;
      rxBitCnt      <= '0;
      rxTickCnt     <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rxMeta   <= serial_in;
      rxSync   <= rxMeta;
      rxState  <= rxNext;
      rx_valid <= rxFinish;
      if (rxSample) begin
        rxShift <= rxShifted;
      end
      if (rxCapParity) begin
        rxParBit <= rxSync;
      end
      if (rxBitClr) begin
        rxBitCnt <= '0;
      end else if (rxBitInc) begin
        rxBitCnt <= rxBitCnt + 5'd1;
      end
      if (rxClear || rxRestart) begin
        rxTickCnt <= '0;
      end else if (rxTick) begin
        rxTickCnt <= (rxTickCnt == TICK_LAST) ? '0 : rxTickCnt + TICK_W'(1);
      end
      if (rxFinish) begin
        rx_data       <= rxShift;
        rx_parity_err <= PARITY_EN && (calcParity(16'(rxShift), PARITY_ODD) != rxParBit);
        rx_frame_err  <= !rxSync;
      end
    end
  end

endmodule
